kong_game_ctrl: RTL and testbench
=================================

// Module: kong_game_ctrl
// PURPOSE
//  Game-level sequencer around the Kong player datapath: holds Kong in reset, respawns it, detects death
//  (enemy hit, fall off screen, level timeout) and goal reach, and tracks lives, level and time.
//  Drives kong_resetN and freeze (keypad gate) into the player logic; its state feeds the HUD/screen mux.
//  All decisions are taken once per frame, on startOfFrame.
// PARAMETERS
//  START_LIVES   3    lives loaded on game start (1..7)
//  NUM_LEVELS    4    levels to clear before WIN (1..16)
//  LEVEL_TIME    99   seconds per attempt, reloaded on every respawn (1..255)
//  FPS           60   frames per second for the level timer
//  DEATH_FRAMES  90   frames spent in DYING
//  DONE_FRAMES   120  frames spent in LEVEL_DONE
//  FALL_LIMIT_Y  480  kong_y strictly greater than this (signed compare) = fell off screen
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  startOfFrame   in   1   one-cycle pulse per video frame
//  start_key      in   1   start/restart request from keypad (level, any length)
//  collision_enemy in  1   Kong pixel overlaps enemy this cycle
//  collision_goal in   1   Kong pixel overlaps goal object this cycle
//  kong_y         in   11  Kong topLeftY, signed pixels
//  kong_resetN    out  1   active-low reset to the player logic
//  freeze         out  1   1 = keypad requests to Kong are masked
//  game_state     out  3   IDLE=0 RESPAWN=1 PLAY=2 DYING=3 LEVEL_DONE=4 GAME_OVER=5 WIN=6
//  lives          out  3   remaining lives
//  level          out  4   current level, 0-based
//  time_left      out  8   seconds left in the current attempt
// BEHAVIOUR
//  - Reset: game_state=IDLE, lives=0, level=0, time_left=0, kong_resetN=0, freeze=1, all counters/latches 0.
//  - Sticky latches: start_key, collision_enemy, collision_goal OR-accumulate between frames;
//    consumed and cleared on the startOfFrame cycle. Events arriving on the SOF cycle count for the next frame.
//  - All registered outputs update on the SOF clock edge (visible the cycle after SOF). No change between SOFs.
//  - kong_resetN=0 in IDLE and RESPAWN, else 1. freeze=0 only in PLAY.
//  - IDLE: start latched -> RESPAWN; lives=START_LIVES, level=0.
//  - RESPAWN: lasts exactly one frame; time_left=LEVEL_TIME, frame counter=0 -> PLAY.
//  - PLAY, evaluated at each SOF, priority goal > death:
//      goal latched -> LEVEL_DONE.
//      enemy latched | kong_y > FALL_LIMIT_Y | time_left==0 -> DYING.
//      else frame counter++; on reaching FPS-1 it wraps to 0 and time_left-- (saturates at 0).
//  - DYING: wait counter counts SOFs; after DEATH_FRAMES: lives==1 -> lives=0, GAME_OVER;
//    else lives-1 -> RESPAWN.
//  - LEVEL_DONE: after DONE_FRAMES: level==NUM_LEVELS-1 -> WIN; else level+1 -> RESPAWN (lives kept).
//  - GAME_OVER / WIN: hold outputs; start latched -> IDLE (lives/level cleared on that transition).
//  - start_key ignored in RESPAWN/PLAY/DYING/LEVEL_DONE (latch still cleared each SOF).
//  - Wait counter cleared on every state entry; width sized for max(DEATH_FRAMES, DONE_FRAMES).
//  - reset asserted mid-game: immediate return to reset values on the next edge, no pending event survives.
// CONFIGURATION
//  KONG_CHEAT_LIVES_EN defined: DYING -> RESPAWN always, lives never decremented, GAME_OVER unreachable.
//  Not defined: lives behaviour exactly as above.
// TESTING
//  1 reset, 3 frames idle -> state=0, kong_resetN=0, freeze=1, lives=0; start pulse -> RESPAWN 1 frame, PLAY, lives=3, time_left=99.
//  2 PLAY, 60 SOFs with no events -> time_left=98; LEVEL_TIME=2 run -> time_left 0, next SOF -> DYING.
//  3 PLAY, collision_enemy 1 cycle mid-frame -> DYING at next SOF, 90 frames later RESPAWN, lives=2.
//  4 PLAY, collision_goal and enemy in same frame -> LEVEL_DONE, lives unchanged; after 120 frames level=1, RESPAWN.
//  5 lives=1, kong_y=481 at SOF -> DYING, then GAME_OVER lives=0; start -> IDLE; with KONG_CHEAT_LIVES_EN -> RESPAWN, lives=1.
//  6 level=3 goal -> WIN after 120 frames; reset asserted during DYING -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/kong_game_ctrl.sv
// Kong game sequencer: respawn, death/goal detection, lives/level/timer, stepped once per video frame.
// Build option KONG_CHEAT_LIVES_EN: deaths always respawn and never cost a life.
module kong_game_ctrl #(
  parameter int START_LIVES  = 3,
  parameter int NUM_LEVELS   = 4,
  parameter int LEVEL_TIME   = 99,
  parameter int FPS          = 60,
  parameter int DEATH_FRAMES = 90,
  parameter int DONE_FRAMES  = 120,
  parameter int FALL_LIMIT_Y = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        collision_enemy,
  input  logic        collision_goal,
  input  logic [10:0] kong_y,
  output logic        kong_resetN,
  output logic        freeze,
  output logic [2:0]  game_state,
  output logic [2:0]  lives,
  output logic [3:0]  level,
  output logic [7:0]  time_left
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESPAWN    = 3'd1,
    S_PLAY       = 3'd2,
    S_DYING      = 3'd3,
    S_LEVEL_DONE = 3'd4,
    S_GAME_OVER  = 3'd5,
    S_WIN        = 3'd6
  } state_e;

  localparam int WAIT_MAX = (DEATH_FRAMES > DONE_FRAMES) ? DEATH_FRAMES : DONE_FRAMES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int FRAME_W  = $clog2(FPS + 1);

  localparam logic [WAIT_W-1:0]  DEATH_LAST = WAIT_W'(DEATH_FRAMES - 1);
  localparam logic [WAIT_W-1:0]  DONE_LAST  = WAIT_W'(DONE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FPS - 1);
  localparam logic signed [10:0] FALL_Y     = 11'(FALL_LIMIT_Y);
  localparam logic [2:0]         LIVES_INIT = 3'(START_LIVES);
  localparam logic [3:0]         LEVEL_LAST = 4'(NUM_LEVELS - 1);
  localparam logic [7:0]         TIME_INIT  = 8'(LEVEL_TIME);

  state_e             state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [3:0]         level_q, level_d;
  logic [7:0]         time_left_q, time_left_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               start_lat_q, start_lat_d;
  logic               enemy_lat_q, enemy_lat_d;
  logic               goal_lat_q, goal_lat_d;
  logic               fell;

  assign fell = $signed(kong_y) > FALL_Y;

  // NOTE: sequential state uses <= so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lives_q     <= '0;
      level_q     <= '0;
      time_left_q <= '0;
      frame_cnt_q <= '0;
      wait_cnt_q  <= '0;
      start_lat_q <= 1'b0;
      enemy_lat_q <= 1'b0;
      goal_lat_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      time_left_q <= time_left_d;
      frame_cnt_q <= frame_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      start_lat_q <= start_lat_d;
      enemy_lat_q <= enemy_lat_d;
      goal_lat_q  <= goal_lat_d;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    time_left_d = time_left_q;
    frame_cnt_d = frame_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    start_lat_d = start_lat_q | start_key;
    enemy_lat_d = enemy_lat_q | collision_enemy;
    goal_lat_d  = goal_lat_q | collision_goal;

    if (startOfFrame) begin
      // Latches are consumed now; anything arriving on this cycle belongs to the next frame.
      start_lat_d = start_key;
      enemy_lat_d = collision_enemy;
      goal_lat_d  = collision_goal;

      case (state_q)
        S_IDLE: begin
          if (start_lat_q) begin
            state_d = S_RESPAWN;
            lives_d = LIVES_INIT;
            level_d = '0;
          end
        end
        S_RESPAWN: begin
          state_d     = S_PLAY;
          time_left_d = TIME_INIT;
          frame_cnt_d = '0;
        end
        S_PLAY: begin
          if (goal_lat_q) begin
            state_d = S_LEVEL_DONE;
          end else if (enemy_lat_q || fell || (time_left_q == '0)) begin
            state_d = S_DYING;
          end else if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            if (time_left_q != '0) time_left_d = time_left_q - 8'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
        S_DYING: begin
          if (wait_cnt_q == DEATH_LAST) begin
`ifdef KONG_CHEAT_LIVES_EN
            state_d = S_RESPAWN;
`else
            if (lives_q == 3'd1) begin
              lives_d = '0;
              state_d = S_GAME_OVER;
            end else begin
              lives_d = lives_q - 3'd1;
              state_d = S_RESPAWN;
            end
`endif
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        S_LEVEL_DONE: begin
          if (wait_cnt_q == DONE_LAST) begin
            if (level_q == LEVEL_LAST) begin
              state_d = S_WIN;
            end else begin
              level_d = level_q + 4'd1;
              state_d = S_RESPAWN;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        S_GAME_OVER, S_WIN: begin
          if (start_lat_q) begin
            state_d = S_IDLE;
            lives_d = '0;
            level_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) wait_cnt_d = '0;
    end
  end

  assign kong_resetN = !((state_q == S_IDLE) || (state_q == S_RESPAWN));
  assign freeze      = (state_q != S_PLAY);
  assign game_state  = state_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign time_left   = time_left_q;

endmodule

// File: tb/tb_kong_game_ctrl.sv
// Bench for kong_game_ctrl: a default-sized instance and a fast small-parameter instance share stimulus
// and are both compared against a frame-level reference model of the game rules.
module tb_kong_game_ctrl;

  localparam int          GAP       = 3;
  localparam logic [10:0] KY_SAFE   = 11'h7EC;  // -20: above both fall limits
  localparam logic [19:0] RESET_VEC = {3'd0, 1'b0, 1'b1, 3'd0, 4'd0, 8'd0};
`ifdef KONG_CHEAT_LIVES_EN
  localparam bit CHEAT = 1'b1;
`else
  localparam bit CHEAT = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RESPAWN = 1, M_PLAY = 2, M_DYING = 3, M_DONE = 4, M_OVER = 5, M_WIN = 6;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, start_key, collision_enemy, collision_goal;
  logic [10:0] kong_y;
  logic        kr0, fz0, kr1, fz1;
  logic [2:0]  gs0, gs1, lv0, lv1;
  logic [3:0]  lvl0, lvl1;
  logic [7:0]  tl0, tl1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kong_game_ctrl u_dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_key(start_key),
    .collision_enemy(collision_enemy), .collision_goal(collision_goal), .kong_y(kong_y),
    .kong_resetN(kr0), .freeze(fz0), .game_state(gs0), .lives(lv0), .level(lvl0), .time_left(tl0)
  );

  kong_game_ctrl #(
    .START_LIVES(2), .NUM_LEVELS(2), .LEVEL_TIME(2), .FPS(4),
    .DEATH_FRAMES(3), .DONE_FRAMES(5), .FALL_LIMIT_Y(-10)
  ) u_dut_fast (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_key(start_key),
    .collision_enemy(collision_enemy), .collision_goal(collision_goal), .kong_y(kong_y),
    .kong_resetN(kr1), .freeze(fz1), .game_state(gs1), .lives(lv1), .level(lvl1), .time_left(tl1)
  );

  // Reference model: per-instance game state, stepped by the rules once per frame.
  int m_st[2], m_lives[2], m_level[2], m_tl[2], m_play[2], m_dwell[2];
  bit lat_start, lat_enemy, lat_goal;

  function automatic int p_lives(input int i);  return (i == 0) ? 3   : 2;   endfunction
  function automatic int p_levels(input int i); return (i == 0) ? 4   : 2;   endfunction
  function automatic int p_time(input int i);   return (i == 0) ? 99  : 2;   endfunction
  function automatic int p_fps(input int i);    return (i == 0) ? 60  : 4;   endfunction
  function automatic int p_death(input int i);  return (i == 0) ? 90  : 3;   endfunction
  function automatic int p_done(input int i);   return (i == 0) ? 120 : 5;   endfunction
  function automatic int p_fall(input int i);   return (i == 0) ? 480 : -10; endfunction

  task automatic model_frame(input int i, input int ky);
    case (m_st[i])
      M_IDLE: if (lat_start) begin
        m_st[i] = M_RESPAWN; m_lives[i] = p_lives(i); m_level[i] = 0;
      end
      M_RESPAWN: begin
        m_st[i] = M_PLAY; m_play[i] = 0; m_tl[i] = p_time(i);
      end
      M_PLAY: begin
        if (lat_goal) begin
          m_st[i] = M_DONE; m_dwell[i] = 0;
        end else if (lat_enemy || ky > p_fall(i) || m_tl[i] == 0) begin
          m_st[i] = M_DYING; m_dwell[i] = 0;
        end else begin
          m_play[i]++;
          m_tl[i] = p_time(i) - m_play[i] / p_fps(i);
          if (m_tl[i] < 0) m_tl[i] = 0;
        end
      end
      M_DYING: begin
        m_dwell[i]++;
        if (m_dwell[i] == p_death(i)) begin
          if (CHEAT) m_st[i] = M_RESPAWN;
          else if (m_lives[i] == 1) begin m_lives[i] = 0; m_st[i] = M_OVER; end
          else begin m_lives[i]--; m_st[i] = M_RESPAWN; end
        end
      end
      M_DONE: begin
        m_dwell[i]++;
        if (m_dwell[i] == p_done(i)) begin
          if (m_level[i] == p_levels(i) - 1) m_st[i] = M_WIN;
          else begin m_level[i]++; m_st[i] = M_RESPAWN; end
        end
      end
      default: if (lat_start) begin
        m_st[i] = M_IDLE; m_lives[i] = 0; m_level[i] = 0;
      end
    endcase
  endtask

  task automatic model_edge();
    int ky;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = M_IDLE; m_lives[i] = 0; m_level[i] = 0;
        m_tl[i] = 0; m_play[i] = 0; m_dwell[i] = 0;
      end
      lat_start = 0; lat_enemy = 0; lat_goal = 0;
    end else if (startOfFrame) begin
      ky = $signed(kong_y);
      for (int i = 0; i < 2; i++) model_frame(i, ky);
      lat_start = start_key; lat_enemy = collision_enemy; lat_goal = collision_goal;
    end else begin
      lat_start |= start_key; lat_enemy |= collision_enemy; lat_goal |= collision_goal;
    end
  endtask

  function automatic logic [19:0] exp_vec(input int i);
    logic rn, fz;
    rn = !(m_st[i] == M_IDLE || m_st[i] == M_RESPAWN);
    fz = (m_st[i] != M_PLAY);
    return {3'(m_st[i]), rn, fz, 3'(m_lives[i]), 4'(m_level[i]), 8'(m_tl[i])};
  endfunction

  function automatic logic [19:0] obs(input int i);
    return (i == 0) ? {gs0, kr0, fz0, lv0, lvl0, tl0} : {gs1, kr1, fz1, lv1, lvl1, tl1};
  endfunction

  // One clock: drive at negedge, model follows the edge, return at the next negedge.
  task automatic tick(input logic sof, input logic sk, input logic ce, input logic cg);
    startOfFrame = sof; start_key = sk; collision_enemy = ce; collision_goal = cg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic frame(input logic sk, input logic ce, input logic cg);
    int pos;
    pos = $urandom_range(0, GAP - 1);
    for (int c = 0; c < GAP; c++) tick(1'b0, sk && c == pos, ce && c == pos, cg && c == pos);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; kong_y = KY_SAFE;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs(i) !== RESET_VEC) begin
          n_errors++; $display("FAIL reset_idle dut%0d frame %0d act=%h exp=%h", i, f, obs(i), RESET_VEC);
        end
      end
      frame(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_start();
    frame(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (gs0 !== 3'd1 || lv0 !== 3'd3 || kr0 !== 1'b0 || fz0 !== 1'b1 || gs1 !== 3'd1 || lv1 !== 3'd2) begin
      n_errors++; $display("FAIL start_respawn act st=%0d/%0d lives=%0d/%0d exp st=1/1 lives=3/2", gs0, gs1, lv0, lv1);
    end
    frame(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (gs0 !== 3'd2 || tl0 !== 8'd99 || kr0 !== 1'b1 || fz0 !== 1'b0 || lv0 !== 3'd3) begin
      n_errors++; $display("FAIL start_play act st=%0d tl=%0d rn=%b fz=%b exp st=2 tl=99 rn=1 fz=0", gs0, tl0, kr0, fz0);
    end
  endtask

  task automatic test_timer();
    for (int f = 1; f <= 60; f++) begin
      frame(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs(i) !== exp_vec(i)) begin
          n_errors++; $display("FAIL timer dut%0d frame %0d act=%h exp=%h", i, f, obs(i), exp_vec(i));
        end
      end
      if (f == 8) begin
        n_checks++;
        if (gs1 !== 3'd2 || tl1 !== 8'd0) begin
          n_errors++; $display("FAIL timeout_zero act st=%0d tl=%0d exp st=2 tl=0", gs1, tl1);
        end
      end
      if (f == 9) begin
        n_checks++;
        if (gs1 !== 3'd3) begin
          n_errors++; $display("FAIL timeout_dying act st=%0d exp st=3", gs1);
        end
      end
    end
    n_checks++;
    if (gs0 !== 3'd2 || tl0 !== 8'd98) begin
      n_errors++; $display("FAIL timer_60 act st=%0d tl=%0d exp st=2 tl=98", gs0, tl0);
    end
  endtask

  task automatic test_enemy();
    frame(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (gs0 !== 3'd3 || lv0 !== 3'd3 || kr0 !== 1'b1 || fz0 !== 1'b1) begin
      n_errors++; $display("FAIL enemy_dying act st=%0d lives=%0d exp st=3 lives=3", gs0, lv0);
    end
    for (int k = 1; k <= 90; k++) begin
      frame(k == 10, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs(i) !== exp_vec(i)) begin
          n_errors++; $display("FAIL dying dut%0d frame %0d act=%h exp=%h", i, k, obs(i), exp_vec(i));
        end
      end
    end
    n_checks++;
    if (gs0 !== 3'd1 || lv0 !== (CHEAT ? 3'd3 : 3'd2) || kr0 !== 1'b0) begin
      n_errors++; $display("FAIL enemy_respawn act st=%0d lives=%0d exp st=1 lives=%0d", gs0, lv0, CHEAT ? 3 : 2);
    end
    frame(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (gs0 !== 3'd2 || tl0 !== 8'd99) begin
      n_errors++; $display("FAIL enemy_replay act st=%0d tl=%0d exp st=2 tl=99", gs0, tl0);
    end
  endtask

  task automatic test_goal_priority();
    frame(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (gs0 !== 3'd4 || lv0 !== (CHEAT ? 3'd3 : 3'd2)) begin
      n_errors++; $display("FAIL goal_priority act st=%0d lives=%0d exp st=4 lives=%0d", gs0, lv0, CHEAT ? 3 : 2);
    end
    for (int k = 1; k <= 120; k++) begin
      frame(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs(i) !== exp_vec(i)) begin
          n_errors++; $display("FAIL level_done dut%0d frame %0d act=%h exp=%h", i, k, obs(i), exp_vec(i));
        end
      end
    end
    n_checks++;
    if (gs0 !== 3'd1 || lvl0 !== 4'd1) begin
      n_errors++; $display("FAIL next_level act st=%0d level=%0d exp st=1 level=1", gs0, lvl0);
    end
    frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fall_game_over();
    kong_y = 11'd480;
    frame(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (gs0 !== 3'd2) begin
      n_errors++; $display("FAIL fall_boundary act st=%0d exp st=2", gs0);
    end
    for (int d = 0; d < 2; d++) begin
      kong_y = 11'd481;
      frame(1'b0, 1'b0, 1'b0);
      kong_y = KY_SAFE;
      n_checks++;
      if (gs0 !== 3'd3) begin
        n_errors++; $display("FAIL fall_dying death %0d act st=%0d exp st=3", d, gs0);
      end
      for (int k = 1; k <= 90; k++) begin
        frame(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (obs(i) !== exp_vec(i)) begin
            n_errors++; $display("FAIL fall dut%0d frame %0d act=%h exp=%h", i, k, obs(i), exp_vec(i));
          end
        end
      end
      if (d == 0) frame(1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (gs0 !== (CHEAT ? 3'd1 : 3'd5) || lv0 !== (CHEAT ? 3'd3 : 3'd0)) begin
      n_errors++; $display("FAIL game_over act st=%0d lives=%0d exp st=%0d lives=%0d", gs0, lv0, CHEAT ? 1 : 5, CHEAT ? 3 : 0);
    end
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (gs0 !== (CHEAT ? 3'd2 : 3'd0) || lv0 !== (CHEAT ? 3'd3 : 3'd0) || lvl0 !== (CHEAT ? 4'd1 : 4'd0)) begin
      n_errors++; $display("FAIL over_restart act st=%0d lives=%0d level=%0d", gs0, lv0, lvl0);
    end
  endtask

  task automatic test_win();
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    for (int lv = 0; lv < 4; lv++) begin
      frame(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (gs0 !== 3'd4 || lvl0 !== 4'(lv)) begin
        n_errors++; $display("FAIL win_goal act st=%0d level=%0d exp st=4 level=%0d", gs0, lvl0, lv);
      end
      for (int k = 1; k <= 120; k++) begin
        frame(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (obs(i) !== exp_vec(i)) begin
            n_errors++; $display("FAIL win_path dut%0d level %0d frame %0d act=%h exp=%h", i, lv, k, obs(i), exp_vec(i));
          end
        end
      end
      if (lv < 3) frame(1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (gs0 !== 3'd6 || lvl0 !== 4'd3 || lv0 !== 3'd3 || kr0 !== 1'b1 || fz0 !== 1'b1) begin
      n_errors++; $display("FAIL win act st=%0d level=%0d lives=%0d exp st=6 level=3 lives=3", gs0, lvl0, lv0);
    end
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (gs0 !== 3'd0 || lv0 !== 3'd0 || lvl0 !== 4'd0 || kr0 !== 1'b0) begin
      n_errors++; $display("FAIL win_restart act st=%0d lives=%0d level=%0d exp 0/0/0", gs0, lv0, lvl0);
    end
  endtask

  task automatic test_reset_mid_game();
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) frame(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (gs0 !== 3'd3) begin
      n_errors++; $display("FAIL mid_dying act st=%0d exp st=3", gs0);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs(i) !== RESET_VEC) begin
        n_errors++; $display("FAIL mid_reset dut%0d act=%h exp=%h", i, obs(i), RESET_VEC);
      end
    end
    frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs(i) !== RESET_VEC) begin
        n_errors++; $display("FAIL reset_no_pending dut%0d act=%h exp=%h", i, obs(i), RESET_VEC);
      end
    end
  endtask

  task automatic test_random();
    int gap;
    for (int f = 0; f < 800; f++) begin
      gap = $urandom_range(1, 4);
      case ($urandom_range(0, 15))
        0:       kong_y = 11'd481;
        1:       kong_y = 11'd480;
        2:       kong_y = 11'h7F6;  // -10
        3:       kong_y = 11'h7F7;  // -9
        4:       kong_y = 11'($urandom);
        default: kong_y = KY_SAFE;
      endcase
      for (int c = 0; c <= gap; c++) begin
        reset = ($urandom_range(0, 299) == 0);
        tick(c == gap, $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (obs(i) !== exp_vec(i)) begin
            n_errors++; $display("FAIL random dut%0d frame %0d cycle %0d act=%h exp=%h", i, f, c, obs(i), exp_vec(i));
          end
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_timer();
    test_enemy();
    test_goal_priority();
    test_fall_game_over();
    test_win();
    test_reset_mid_game();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
